// File: rtl/config_chain_sink.sv
// Four-lane serial configuration sink: each lane shifts a frame into a staging
// register and commits it to an active register on a set rising edge.
module config_chain_sink #(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = $clog2(CHAIN_LEN+2)
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   cen,
   input  logic [3:0]             set_in,
   input  logic [3:0]             shift_in,
   output logic [4*CHAIN_LEN-1:0] config_o,
   output logic [3:0]             chain_out,
   output logic [3:0]             loaded,
   output logic [3:0]             err
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(CHAIN_LEN + 1);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [CHAIN_LEN-1:0] stage_q;
      logic [CHAIN_LEN-1:0] active_q;
      logic [CNT_W-1:0]     cnt_q;
      logic                 setq_q;
      logic                 loaded_q;
      logic                 err_q;
      logic                 set_edge;

      assign set_edge = set_in[l] & ~setq_q;

      // setq resets high so a set held through reset release is not an edge;
      // the counter saturates one past a full frame to flag overlong frames.
      always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
         if (!wb_rst_i) begin
            stage_q  <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            setq_q   <= 1'b1;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
         end else begin
            setq_q <= set_in[l];
            if (cen) begin
               stage_q <= {stage_q[CHAIN_LEN-2:0], shift_in[l]};
            end
            if (set_edge) begin
               if (!cen && cnt_q == FULL_CNT) begin
                  active_q <= stage_q;
                  loaded_q <= 1'b1;
                  err_q    <= 1'b0;
               end else begin
                  err_q <= 1'b1;
               end
               cnt_q <= '0;
            end else if (cen && cnt_q != SAT_CNT) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end

      assign config_o[l*CHAIN_LEN +: CHAIN_LEN] = active_q;
      assign chain_out[l] = stage_q[CHAIN_LEN-1];
      assign loaded[l]    = loaded_q;
      assign err[l]       = err_q;
   end

endmodule

// File: tb/tb_config_chain_sink.sv
// Directed self-checking bench for config_chain_sink with CHAIN_LEN = 8.
module tb_config_chain_sink;

   localparam int CHAIN_LEN = 8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b0;
   logic        cen      = 1'b0;
   logic [3:0]  set_in   = 4'h0;
   logic [3:0]  shift_in = 4'h0;
   logic [31:0] config_o;
   logic [3:0]  chain_out;
   logic [3:0]  loaded;
   logic [3:0]  err;

   int assertCount = 0;
   int failCount   = 0;

   config_chain_sink #(.CHAIN_LEN(CHAIN_LEN)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .cen      (cen),
      .set_in   (set_in),
      .shift_in (shift_in),
      .config_o (config_o),
      .chain_out(chain_out),
      .loaded   (loaded),
      .err      (err)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Drive inputs, then advance one rising edge; outputs are sampled 1ns later.
   task automatic applyStimulus(input logic c, input logic [3:0] s, input logic [3:0] d);
      cen      = c;
      set_in   = s;
      shift_in = d;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Shift n bits per lane, MSB first; lane l's byte is data[l*8 +: 8], bits past 8 are zero.
   task automatic shiftFrame(input logic [31:0] data, input int n);
      logic [3:0] bits;
      for (int i = 0; i < n; i++) begin
         int k;
         k = n - 1 - i;
         for (int l = 0; l < 4; l++) begin
            bits[l] = (k < 8) ? data[l*8 + k] : 1'b0;
         end
         applyStimulus(1'b1, 4'h0, bits);
      end
   endtask

   task automatic doReset();
      cen      = 1'b0;
      set_in   = 4'h0;
      shift_in = 4'h0;
      wb_rst_i = 1'b0;
      repeat (2) @(posedge wb_clk_i);
      #3;
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
   endtask

   logic [7:0] readPattern;

   initial begin
      $display("[TB] start");

      // Reset state
      doReset();
      checkOutput("rst_config", config_o, 32'h0);
      checkOutput("rst_loaded", {28'h0, loaded}, 32'h0);
      checkOutput("rst_err", {28'h0, err}, 32'h0);
      checkOutput("rst_chain", {28'h0, chain_out}, 32'h0);

      // Good load on lane 0
      shiftFrame(32'h000000B2, 8);
      applyStimulus(1'b0, 4'b0001, 4'h0);
      checkOutput("good_config", config_o, 32'h000000B2);
      checkOutput("good_loaded", {28'h0, loaded}, 32'h1);
      checkOutput("good_err", {28'h0, err}, 32'h0);
      checkOutput("good_chain", {28'h0, chain_out}, 32'h1);
      applyStimulus(1'b0, 4'h0, 4'h0);

      // Short, long, then good frame on lane 1
      doReset();
      shiftFrame(32'h00005500, 7);
      applyStimulus(1'b0, 4'b0010, 4'h0);
      checkOutput("short_err", {28'h0, err}, 32'h2);
      checkOutput("short_config", config_o, 32'h0);
      checkOutput("short_loaded", {28'h0, loaded}, 32'h0);
      applyStimulus(1'b0, 4'h0, 4'h0);
      shiftFrame(32'h0000FF00, 12);
      applyStimulus(1'b0, 4'b0010, 4'h0);
      checkOutput("long_err", {28'h0, err}, 32'h2);
      checkOutput("long_config", config_o, 32'h0);
      applyStimulus(1'b0, 4'h0, 4'h0);
      shiftFrame(32'h0000C300, 8);
      applyStimulus(1'b0, 4'b0010, 4'h0);
      checkOutput("recover_config", config_o, 32'h0000C300);
      checkOutput("recover_loaded", {28'h0, loaded}, 32'h2);
      checkOutput("recover_err", {28'h0, err}, 32'h0);
      applyStimulus(1'b0, 4'h0, 4'h0);

      // Set while shifting on lane 2
      doReset();
      shiftFrame(32'h00AA0000, 8);
      checkOutput("pre_busy_chain", {28'h0, chain_out}, 32'h4);
      applyStimulus(1'b1, 4'b0100, 4'h0);
      checkOutput("busy_err", {28'h0, err}, 32'h4);
      checkOutput("busy_config", config_o, 32'h0);
      checkOutput("busy_loaded", {28'h0, loaded}, 32'h0);
      checkOutput("busy_shifted", {28'h0, chain_out}, 32'h0);
      applyStimulus(1'b0, 4'h0, 4'h0);
      shiftFrame(32'h003C0000, 8);
      applyStimulus(1'b0, 4'b0100, 4'h0);
      checkOutput("fresh_config", config_o, 32'h003C0000);
      checkOutput("fresh_loaded", {28'h0, loaded}, 32'h4);
      checkOutput("fresh_err", {28'h0, err}, 32'h0);
      applyStimulus(1'b0, 4'h0, 4'h0);

      // Parallel lanes with set held for five cycles
      doReset();
      shiftFrame(32'h5AFF8001, 8);
      applyStimulus(1'b0, 4'hF, 4'h0);
      checkOutput("par_config", config_o, 32'h5AFF8001);
      checkOutput("par_loaded", {28'h0, loaded}, 32'hF);
      checkOutput("par_err", {28'h0, err}, 32'h0);
      checkOutput("par_chain", {28'h0, chain_out}, 32'h6);
      repeat (4) applyStimulus(1'b0, 4'hF, 4'h0);
      checkOutput("held_err", {28'h0, err}, 32'h0);
      checkOutput("held_config", config_o, 32'h5AFF8001);
      applyStimulus(1'b0, 4'h0, 4'h0);

      // Readback of lane 3 through chain_out
      readPattern = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("readback_bit%0d", i), {31'h0, chain_out[3]},
                     {31'h0, readPattern[7-i]});
         applyStimulus(1'b1, 4'h0, 4'h0);
      end
      checkOutput("readback_config", config_o, 32'h5AFF8001);
      checkOutput("readback_empty", {28'h0, chain_out}, 32'h0);

      // Reset mid-frame with set held high through release
      applyStimulus(1'b0, 4'h0, 4'h0);
      shiftFrame(32'hFFFFFFFF, 4);
      cen      = 1'b0;
      set_in   = 4'hF;
      wb_rst_i = 1'b0;
      #1;
      checkOutput("async_config", config_o, 32'h0);
      checkOutput("async_loaded", {28'h0, loaded}, 32'h0);
      checkOutput("async_err", {28'h0, err}, 32'h0);
      repeat (2) @(posedge wb_clk_i);
      #3;
      wb_rst_i = 1'b1;
      repeat (2) applyStimulus(1'b0, 4'hF, 4'h0);
      checkOutput("release_err", {28'h0, err}, 32'h0);
      checkOutput("release_loaded", {28'h0, loaded}, 32'h0);
      checkOutput("release_config", config_o, 32'h0);
      applyStimulus(1'b0, 4'h0, 4'h0);
      shiftFrame(32'h12345678, 8);
      applyStimulus(1'b0, 4'hF, 4'h0);
      checkOutput("post_rst_config", config_o, 32'h12345678);
      checkOutput("post_rst_loaded", {28'h0, loaded}, 32'hF);
      checkOutput("post_rst_err", {28'h0, err}, 32'h0);
      applyStimulus(1'b0, 4'h0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
